debug_display: RTL and testbench
================================

Name: debug_display

Overview:
Parametrised successor to the fixed 4-digit PC display on the FPGA board's seven-segment block. It accepts NCHAN debug channels, for example PC, keyboard scancode, rc_state and disk_state. It captures the selected channel, free-running or strobe-latched per channel, and time-multiplexes NDIGITS hex digits plus decimal points onto the active-low segment/anode pins. Button pulses cycle the channel; a freeze input holds the captured value.

Parameters:
NDIGITS, 4, number of hex digits/anodes driven (1..8)
NCHAN, 4, number of input channels (>=1)
DIV_BITS, 16, width of scan divider; one digit period = 2^DIV_BITS clk cycles
BLANK_CYCLES, 16, anode-off cycles at start of each digit period (anti-ghosting); must be < 2^DIV_BITS
STICKY_MASK, {NCHAN{1'b0}}, bit c=1: channel c captured only on chan_strobe[c]; 0: captured every cycle

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
chan_data  in  NCHAN*NDIGITS*4  channel c occupies [c*NDIGITS*4 +: NDIGITS*4]; digit 0 = least significant nibble
chan_dots  in  NCHAN*NDIGITS  per-channel decimal points, 1 = lit; bit d = digit d
chan_strobe  in  NCHAN  capture qualifier for sticky channels (single-cycle pulse)
sel_next  in  1  raw button level; rising edge advances channel
freeze  in  1  level; 1 holds captured value/dots
sevenseg  out  8  active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
sevenseg_an  out  NDIGITS  active-low anode enables, bit d = digit d
cur_chan  out  max(1,$clog2(NCHAN))  currently selected channel

Behaviour:
- Reset values: sevenseg=8'hFF, sevenseg_an=all 1, cur_chan=0, digit index=0, divider=0, capture regs=0, sync/edge flops=0.
- sel_next: 2-flop synchroniser followed by an edge flop; a rising edge gives a 1-cycle pulse.
- On the pulse, cur_chan increments, wrapping NCHAN-1 -> 0. It does not wrap at the power of two.
- Channel change clears the capture regs to 0 in the same cycle as cur_chan updates. A sticky channel therefore shows 0 until its first strobe.
- Capture (cycle after sample), when freeze=0:
  - non-sticky channel: cap_data/cap_dots <= selected channel every cycle.
  - sticky channel: cap_data/cap_dots load only when chan_strobe[cur_chan]=1. Strobes on unselected channels are ignored.
- freeze=1 blocks all capture loads. Channel change still occurs and still clears the capture regs (they clear and then hold 0).
- Simultaneous channel-change pulse and strobe: the change wins; the register is cleared and the strobe is dropped.
- Scan:
  - divider counts 0..2^DIV_BITS-1 and wraps.
  - On wrap, digit index increments, wrapping NDIGITS-1 -> 0.
  - NDIGITS=1: index stays 0.
- Outputs (registered, one cycle after the divider/index):
  - divider < BLANK_CYCLES: sevenseg_an=all 1 and sevenseg=8'hFF.
  - otherwise: sevenseg_an = ~(1<<index); sevenseg[6:0] = hex decode of cap nibble[index]; sevenseg[7] = ~cap_dots[index].
- Hex decode (active-low, g..a):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Latency:
  - non-sticky input change -> segment change at most 2 cycles after, when that digit is active and unblanked.
  - button edge -> cur_chan change 3 cycles after.
- Reset asserted mid-scan or mid-capture returns every register to its reset value on the next edge. No partial frame is emitted afterwards.

Decomposition:
- Shared package debug_display_pkg holds:
  - SEG_BLANK=8'hFF
  - the 16-entry hex-to-segment constant table
  - chan width helper function CHW(NCHAN)=max(1,$clog2(NCHAN))
- One combinational sub-module, hex7seg_decode (nibble + dp -> 8-bit active-low), keeps the table reusable by other board displays.
- Scan timer, channel select and capture stay in debug_display.

Test Plan (DIV_BITS=4, BLANK_CYCLES=2, NDIGITS=4, NCHAN=3, STICKY_MASK=3'b010):
- Reset release, ch0 data=16'h1234, dots=0:
  - cycles 0-1 of each period: an=4'hF, seg=8'hFF.
  - then digits 0..3 show 8'h99, 8'hB0, 8'hA4, 8'hF9 with an=E, D, B, 7.
  - index wraps 3 -> 0 after 64 cycles.
- Three sel_next rising edges (each held 5 cycles) -> cur_chan 1, 2, 0. Each update lands 3 cycles after its edge.
- Select sticky ch1 with chan_data ch1=16'hABCD and no strobe -> all digits show 8'hC0 ("0").
  - Then one strobe -> digit 3 shows 8'h88.
  - Change ch1 data to 16'h5555 without a strobe -> display still ABCD.
- ch0 non-sticky: set freeze=1, change data 16'h1234 -> 16'hFFFF -> display holds 1234.
  - freeze=0 -> all digits show 8'h8E within 2 cycles plus the scan position.
- dots=4'b0101 on ch0 -> sevenseg[7]=0 only on digits 0 and 2.
- Assert reset while digit 2 is active -> next cycle: an=F, seg=FF, cur_chan=0, index=0.

Source files
------------

// File: rtl/debug_display_pkg.sv
// Shared seven-segment constants and sizing helpers for the board display blocks.
package debug_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns, entry n = hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int CHW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Nibble plus decimal point to active-low {dp,g..a} segment pattern.
module hex7seg_decode
  import debug_display_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {~i_dp, HEX_SEG[i_nib]};

endmodule

// File: rtl/debug_display.sv
// Multi-channel debug value capture and time-multiplexed hex display driver.
module debug_display
  import debug_display_pkg::*;
#(
  parameter int               NDIGITS      = 4,
  parameter int               NCHAN        = 4,
  parameter int               DIV_BITS     = 16,
  parameter int               BLANK_CYCLES = 16,
  parameter logic [NCHAN-1:0] STICKY_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCHAN*NDIGITS*4-1:0] chan_data,
  input  logic [NCHAN*NDIGITS-1:0]   chan_dots,
  input  logic [NCHAN-1:0]           chan_strobe,
  input  logic                       sel_next,
  input  logic                       freeze,
  output logic [7:0]                 sevenseg,
  output logic [NDIGITS-1:0]         sevenseg_an,
  output logic [CHW(NCHAN)-1:0]      cur_chan
);

  localparam int CW = CHW(NCHAN);
  localparam int IW = CHW(NDIGITS);
  localparam int DW = NDIGITS * 4;
  localparam logic [DIV_BITS-1:0] BLANK_V = DIV_BITS'(BLANK_CYCLES);

  logic               r_sel_s1, r_sel_s2, r_sel_d;
  logic               w_sel_pulse;
  logic [CW-1:0]      r_chan;
  logic [DW-1:0]      r_cap, w_chan_data;
  logic [NDIGITS-1:0] r_dots, w_chan_dots;
  logic               w_sticky, w_strobe;
  logic [DIV_BITS-1:0] r_div;
  logic [IW-1:0]      r_idx;
  logic [3:0]         w_nib;
  logic               w_dp;
  logic [7:0]         w_seg, r_seg;
  logic [NDIGITS-1:0] r_an;

  assign w_sel_pulse = r_sel_s2 & ~r_sel_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_s1 <= 1'b0;
      r_sel_s2 <= 1'b0;
      r_sel_d  <= 1'b0;
      r_chan   <= '0;
    end else begin
      r_sel_s1 <= sel_next;
      r_sel_s2 <= r_sel_s1;
      r_sel_d  <= r_sel_s2;
      if (w_sel_pulse)
        r_chan <= (r_chan == CW'(NCHAN - 1)) ? '0 : r_chan + 1'b1;
    end
  end

  always_comb begin
    w_chan_data = '0;
    w_chan_dots = '0;
    w_sticky    = 1'b0;
    w_strobe    = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      if (r_chan == CW'(c)) begin
        w_chan_data = chan_data[c*DW +: DW];
        w_chan_dots = chan_dots[c*NDIGITS +: NDIGITS];
        w_sticky    = STICKY_MASK[c];
        w_strobe    = chan_strobe[c];
      end
    end
  end

  // A channel change wins over a coincident strobe so the new channel starts from 0
  always_ff @(posedge clk) begin
    if (reset || w_sel_pulse) begin
      r_cap  <= '0;
      r_dots <= '0;
    end else if (!freeze && (!w_sticky || w_strobe)) begin
      r_cap  <= w_chan_data;
      r_dots <= w_chan_dots;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else begin
      r_div <= r_div + 1'b1;
      if (r_div == '1)
        r_idx <= (r_idx == IW'(NDIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_nib = '0;
    w_dp  = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (r_idx == IW'(d)) begin
        w_nib = r_cap[d*4 +: 4];
        w_dp  = r_dots[d];
      end
    end
  end

  hex7seg_decode u_dec (
    .i_nib (w_nib),
    .i_dp  (w_dp),
    .o_seg (w_seg)
  );

  // Anodes stay off for the first BLANK_CYCLES of each digit to hide ghosting
  always_ff @(posedge clk) begin
    if (reset || r_div < BLANK_V) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_an  <= ~(NDIGITS'(1) << r_idx);
    end
  end

  assign sevenseg    = r_seg;
  assign sevenseg_an = r_an;
  assign cur_chan    = r_chan;

endmodule

// File: tb/tb_debug_display.sv
// Self-checking bench: directed plan steps plus random traffic against a cycle model.
module tb_debug_display;

  localparam int NDIGITS = 4;
  localparam int NCHAN   = 3;
  localparam int DIVB    = 4;
  localparam int BLANK   = 2;
  localparam logic [NCHAN-1:0] STICKY = 3'b010;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NCHAN*NDIGITS*4-1:0] chan_data;
  logic [NCHAN*NDIGITS-1:0]   chan_dots;
  logic [NCHAN-1:0]           chan_strobe;
  logic                       sel_next;
  logic                       freeze;
  logic [7:0]                 sevenseg;
  logic [NDIGITS-1:0]         sevenseg_an;
  logic [1:0]                 cur_chan;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  debug_display #(
    .NDIGITS(NDIGITS), .NCHAN(NCHAN), .DIV_BITS(DIVB),
    .BLANK_CYCLES(BLANK), .STICKY_MASK(STICKY)
  ) dut (
    .clk(clk), .reset(reset), .chan_data(chan_data), .chan_dots(chan_dots),
    .chan_strobe(chan_strobe), .sel_next(sel_next), .freeze(freeze),
    .sevenseg(sevenseg), .sevenseg_an(sevenseg_an), .cur_chan(cur_chan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [6:0] hexref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference: k = cycles since reset release sets scan position; button edges
  // take effect three edges after they are sampled.
  int         k;
  int         m_chan;
  logic [15:0] m_cap;
  logic [3:0]  m_dots;
  logic [2:0]  sh;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;

  always @(posedge clk) begin
    int div, idx;
    bit pulse;
    if (reset) begin
      k = 0; m_chan = 0; m_cap = '0; m_dots = '0; sh = '0;
      e_seg = 8'hFF; e_an = 4'hF;
    end else begin
      div = k % (1 << DIVB);
      idx = (k / (1 << DIVB)) % NDIGITS;
      if (div < BLANK) begin
        e_seg = 8'hFF; e_an = 4'hF;
      end else begin
        e_an  = ~(4'b0001 << idx);
        e_seg = {~m_dots[idx], hexref(m_cap[idx*4 +: 4])};
      end
      pulse = sh[1] & ~sh[2];
      sh    = {sh[1:0], sel_next};
      if (pulse) begin
        m_chan = (m_chan + 1) % NCHAN;
        m_cap  = '0;
        m_dots = '0;
      end else if (!freeze && (!STICKY[m_chan] || chan_strobe[m_chan])) begin
        m_cap  = chan_data[m_chan*16 +: 16];
        m_dots = chan_dots[m_chan*4 +: 4];
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      assert (sevenseg === e_seg) else begin
        n_err++; $error("FAIL model_seg obs=%h exp=%h cyc=%0d", sevenseg, e_seg, cyc);
      end
      n_cmp++;
      assert (sevenseg_an === e_an) else begin
        n_err++; $error("FAIL model_an obs=%h exp=%h cyc=%0d", sevenseg_an, e_an, cyc);
      end
      n_cmp++;
      assert (cur_chan === 2'(m_chan)) else begin
        n_err++; $error("FAIL model_chan obs=%0d exp=%0d cyc=%0d", cur_chan, m_chan, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++; $error("FAIL %s obs=%h exp=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_an(input logic [3:0] want);
    int i;
    for (i = 0; i < 200; i++) begin
      if (sevenseg_an === want) break;
      @(negedge clk);
    end
    if (i == 200) begin
      n_cmp++; n_err++;
      $error("FAIL wait_an obs=%h exp=%h (timeout)", sevenseg_an, want);
    end
  endtask

  task automatic pulse_sel(input int old_c, input int new_c);
    sel_next = 1'b1;
    step(2);
    chk("sel_hold", 32'(cur_chan), 32'(old_c));
    step(1);
    chk("sel_lat3", 32'(cur_chan), 32'(new_c));
    step(2);
    sel_next = 1'b0;
    step(5);
  endtask

  initial begin
    int t0;
    reset = 1'b1; chan_data = '0; chan_dots = '0; chan_strobe = '0;
    sel_next = 1'b0; freeze = 1'b0;
    chan_data[15:0] = 16'h1234;
    step(3);
    chk("rst_an", 32'(sevenseg_an), 32'hF);
    chk("rst_seg", 32'(sevenseg), 32'hFF);
    chk("rst_chan", 32'(cur_chan), 32'h0);
    chk_en = 1'b1;
    reset = 1'b0;

    step(1); chk("blank0", 32'(sevenseg), 32'hFF);
    step(1); chk("blank1", 32'(sevenseg_an), 32'hF);
    step(1); chk("d0_first", 32'(sevenseg), 32'h99);
    chk("d0_an", 32'(sevenseg_an), 32'hE);
    wait_an(4'hD); chk("d1_1234", 32'(sevenseg), 32'hB0);
    wait_an(4'hB); chk("d2_1234", 32'(sevenseg), 32'hA4);
    wait_an(4'h7); chk("d3_1234", 32'(sevenseg), 32'hF9);
    wait_an(4'hE); t0 = cyc;
    wait_an(4'h7); wait_an(4'hE);
    chk("frame_64", 32'(cyc - t0), 32'd64);

    pulse_sel(0, 1);
    pulse_sel(1, 2);
    pulse_sel(2, 0);

    chan_data[31:16] = 16'hABCD;
    pulse_sel(0, 1);
    wait_an(4'hE); chk("sticky0_d0", 32'(sevenseg), 32'hC0);
    wait_an(4'h7); chk("sticky0_d3", 32'(sevenseg), 32'hC0);
    chan_strobe[0] = 1'b1; chan_strobe[2] = 1'b1;
    step(1);
    chan_strobe = '0;
    step(3);
    wait_an(4'hE); chk("unsel_strobe", 32'(sevenseg), 32'hC0);
    chan_strobe[1] = 1'b1;
    step(1);
    chan_strobe = '0;
    chan_data[31:16] = 16'h5555;
    wait_an(4'h7); chk("sticky_d3", 32'(sevenseg), 32'h88);
    step(70);
    wait_an(4'h7); chk("sticky_hold3", 32'(sevenseg), 32'h88);
    wait_an(4'hE); chk("sticky_hold0", 32'(sevenseg), 32'hA1);

    pulse_sel(1, 2);
    pulse_sel(2, 0);
    step(3);
    freeze = 1'b1;
    chan_data[15:0] = 16'hFFFF;
    step(70);
    wait_an(4'hE); chk("frz_d0", 32'(sevenseg), 32'h99);
    freeze = 1'b0;
    step(2);
    wait_an(4'hD); chk("unfrz_d1", 32'(sevenseg), 32'h8E);

    chan_dots[3:0] = 4'b0101;
    step(3);
    wait_an(4'hE); chk("dot_d0", 32'(sevenseg), 32'h0E);
    wait_an(4'hD); chk("dot_d1", 32'(sevenseg), 32'h8E);
    wait_an(4'hB); chk("dot_d2", 32'(sevenseg), 32'h0E);
    wait_an(4'h7); chk("dot_d3", 32'(sevenseg), 32'h8E);

    for (int i = 0; i < 800; i++) begin
      chan_data   = {$urandom, $urandom};
      chan_dots   = 12'($urandom);
      chan_strobe = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      freeze      = ($urandom_range(0, 9) == 0) ? ~freeze : freeze;
      if ($urandom_range(0, 15) == 0) sel_next = ~sel_next;
      step(1);
    end
    freeze = 1'b0; sel_next = 1'b0; chan_strobe = '0;
    step(5);
    for (int i = 0; i < 2 && m_chan == 0; i++)
      pulse_sel(m_chan, (m_chan + 1) % NCHAN);

    wait_an(4'hB);
    reset = 1'b1;
    step(1);
    chk("midrst_an", 32'(sevenseg_an), 32'hF);
    chk("midrst_seg", 32'(sevenseg), 32'hFF);
    chk("midrst_chan", 32'(cur_chan), 32'h0);
    reset = 1'b0;
    step(3);
    chk("post_rst_idx0", 32'(sevenseg_an), 32'hE);
    step(40);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
